joy_serial_reader: RTL and testbench

Serial reader for the board's two DB9 joysticks, which sit behind a 16-bit parallel-in/serial-out shift-register chain (74HC165-style). The block drives the chain's load and clock lines and shifts the 16 bits in. It then presents two 6-bit active-high button vectors per frame. It sits directly upstream of the `updater` message/video stage, which consumes `joy1`/`joy2` in {up, down, left, right, fire1, fire2} order on the 7 MHz video clock.

---
 rtl/joy_serial_reader.sv | 202 ++++++++++++++++++++
 tb/tb_joy_serial_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/joy_serial_reader.sv
// -----------------------------------------------------------------------------
// joy_serial_reader
//
// Reads the two DB9 joysticks that sit behind a 16-bit parallel-in/serial-out
// shift-register chain (74HC165 style). The block drives the chain's parallel
// load and shift clock lines and shifts the sampled word in, one bit per
// joy_clk period. At the end of every frame it presents two active-high 6-bit
// button vectors in {up, down, left, right, fire1, fire2} order.
//
// Frame timing: one LOAD tick followed by NBITS (SHIFT_LO, SHIFT_HI) tick pairs,
// i.e. (1 + 2*NBITS)*CLKDIV clk cycles per frame (264 at the defaults).
//
// Parameters:
//   CLKDIV  clk cycles per half-period of joy_clk (>= 2)
//   NBITS   serial bits per frame (16..32); bits above 15 are shifted and dropped
//
// Ports:
//   clk         system clock (7 MHz video clock at top level)
//   rst         asynchronous, active-high reset; aborts any frame in progress
//   joy_data    serial data from the chain's QH output, active-low buttons
//   joy_clk     shift clock to the chain (chain advances on its rising edge)
//   joy_load_n  active-low parallel load to the chain
//   joy1        joystick 1 {up, down, left, right, fire1, fire2}, 1 = pressed
//   joy2        joystick 2, same order
//   frame_done  one-clk pulse on the edge where joy1/joy2 are refreshed
//
// Optional feature (compile-time macro JOY_DEBOUNCE_EN):
//   When defined, joy1/joy2 only update when the 12 sampled button bits of the
//   current frame match those of the previous frame; otherwise they hold.
//   frame_done still pulses every frame. When undefined, no comparison logic
//   or previous-frame register exists and the outputs follow every frame.
// -----------------------------------------------------------------------------
module joy_serial_reader #(
  parameter int CLKDIV = 8,
  parameter int NBITS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       joy_data,
  output logic       joy_clk,
  output logic       joy_load_n,
  output logic [5:0] joy1,
  output logic [5:0] joy2,
  output logic       frame_done
);

  localparam int CNT_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int IDX_W = $clog2(NBITS);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKDIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q;
  logic             tick;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  logic             sample_en;  // capture joy_data this edge
  logic             frame_end;  // last SHIFT_HI tick of the frame
  logic             in_range;   // current bit index lands in the 16-bit word
  logic             update_en;  // outputs may take the new sample

  logic [15:0]      shift_q;    // raw sampled word, active-low buttons
  logic [11:0]      cur_raw;    // the 12 button bits, joy1 then joy2

  assign tick = (cnt_q == CNT_MAX);

  // Bits 16 and above of a long chain are clocked through but never stored.
  generate
    if (IDX_W > 4) begin : g_wide_idx
      assign in_range = (idx_q[IDX_W-1:4] == '0);
    end else begin : g_narrow_idx
      assign in_range = 1'b1;
    end
  endgenerate

  // Bit 0 of the chain comes out first and is joystick 1 "up"; it ends up in
  // the MSB of each 6-bit group so that joy1[5] is up and joy1[0] is fire2.
  assign cur_raw = {shift_q[0], shift_q[1],  shift_q[2],  shift_q[3],
                    shift_q[4], shift_q[5],
                    shift_q[8], shift_q[9],  shift_q[10], shift_q[11],
                    shift_q[12], shift_q[13]};

  // Positions 6, 7, 14 and 15 carry no buttons.
  logic unused_bits;
  assign unused_bits = ^{shift_q[15:14], shift_q[7:6]};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sample_en = 1'b0;
    frame_end = 1'b0;

    if (tick) begin
      unique case (state_q)
        ST_LOAD: begin
          state_d = ST_SHIFT_LO;
          idx_d   = '0;
        end
        ST_SHIFT_LO: begin
          // The chain has had a full half-period with joy_clk low to settle.
          sample_en = 1'b1;
          state_d   = ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          if (idx_q == IDX_LAST) begin
            frame_end = 1'b1;
            state_d   = ST_LOAD;
            idx_d     = '0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_SHIFT_LO;
          end
        end
        default: begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional frame-to-frame debounce
  // ---------------------------------------------------------------------------
`ifdef JOY_DEBOUNCE_EN
  logic [11:0] prev_raw_q;

  // Released (all ones) after reset, so an all-released first frame agrees
  // and a pressed button needs two matching frames before it is reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_raw_q <= '1;
    end else if (frame_end) begin
      prev_raw_q <= cur_raw;
    end
  end

  assign update_en = (prev_raw_q == cur_raw);
`else
  assign update_en = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      // NOTE: the sample register is reset to all ones (buttons released) so
      // no stale presses survive an aborted frame.
      shift_q    <= '1;
      joy_clk    <= 1'b0;
      joy_load_n <= 1'b1;
      joy1       <= '0;
      joy2       <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt_q   <= tick ? '0 : cnt_q + CNT_W'(1);
      state_q <= state_d;
      idx_q   <= idx_d;

      // Pin outputs are registered from the next state, so they change on the
      // same edge as the state and load/clock can never overlap.
      joy_load_n <= (state_d != ST_LOAD);
      joy_clk    <= (state_d == ST_SHIFT_HI);

      frame_done <= frame_end;

      if (sample_en && in_range) begin
        shift_q[idx_q[3:0]] <= joy_data;
      end

      if (frame_end && update_en) begin
        joy1 <= ~cur_raw[11:6];
        joy2 <= ~cur_raw[5:0];
      end
    end
  end

endmodule

// File: tb/tb_joy_serial_reader.sv
// -----------------------------------------------------------------------------
// tb_joy_serial_reader
//
// Directed bench for joy_serial_reader at CLKDIV=8, NBITS=16. A behavioural
// 74HC165 chain model supplies a programmable 16-bit word; expected button
// vectors are hand-computed from that word. A pin monitor counts joy_clk
// rising edges, joy_clk high cycles, joy_load_n low cycles and load/clock
// overlap for every frame.
// -----------------------------------------------------------------------------
module tb_joy_serial_reader;

  localparam int FRAME = 264;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       joy_data;
  logic       joy_clk;
  logic       joy_load_n;
  logic [5:0] joy1;
  logic [5:0] joy2;
  logic       frame_done;

  joy_serial_reader #(
    .CLKDIV(8),
    .NBITS (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .joy_data  (joy_data),
    .joy_clk   (joy_clk),
    .joy_load_n(joy_load_n),
    .joy1      (joy1),
    .joy2      (joy2),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Cycle counter: first edge after reset release is cycle 1
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int fd_base = 0;
  always @(posedge clk) cyc = rst ? 0 : cyc + 1;

  // ---------------------------------------------------------------------------
  // Chain model: QH = sr[0]; load while joy_load_n low, shift on joy_clk rise
  // ---------------------------------------------------------------------------
  logic [15:0] chain_word = 16'hFFFF;
  logic [15:0] chain_sr   = 16'hFFFF;
  logic        jclk_prev  = 1'b0;

  always @(negedge clk) begin
    if (!joy_load_n) chain_sr = chain_word;
    else if (joy_clk && !jclk_prev) chain_sr = {1'b1, chain_sr[15:1]};
    jclk_prev = joy_clk;
  end

  assign joy_data = chain_sr[0];

  // ---------------------------------------------------------------------------
  // Pin monitor, snapshot taken at each frame_done
  // ---------------------------------------------------------------------------
  int   rises = 0, hi_cnt = 0, load_lo = 0, overlap = 0;
  int   snap_rises = 0, snap_hi = 0, snap_load = 0, snap_ovl = 0;
  logic mon_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      rises = 0; hi_cnt = 0; load_lo = 0; overlap = 0; mon_prev = 1'b0;
    end else begin
      if (frame_done) begin
        snap_rises = rises; snap_hi = hi_cnt;
        snap_load  = load_lo; snap_ovl = overlap;
        rises = 0; hi_cnt = 0; load_lo = 0; overlap = 0;
      end
      if (!joy_load_n) load_lo++;
      if (joy_clk) hi_cnt++;
      if (joy_clk && !mon_prev) rises++;
      if (!joy_load_n && joy_clk) overlap++;
      mon_prev = joy_clk;
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Waits for the next frame_done (bounded) and checks its spacing.
  task automatic wait_frame();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!frame_done && n < 600);
    if (!frame_done) check("frame_timeout", 32'd0, 32'd1);
    else check("frame_period", cyc - fd_base, FRAME);
    fd_base = cyc;
  endtask

  // Presents a word to the chain, waits for its frame and checks outputs and
  // pin activity of that frame.
  task automatic run_frame(input string tag, input logic [15:0] word,
                           input logic [5:0] e1, input logic [5:0] e2);
    chain_word = word;
`ifdef JOY_DEBOUNCE_EN
    wait_frame();
`endif
    wait_frame();
    check({tag, "_joy1"}, 32'(joy1), 32'(e1));
    check({tag, "_joy2"}, 32'(joy2), 32'(e2));
    @(negedge clk); #1;
    check({tag, "_rises"},   snap_rises, 16);
    check({tag, "_hi"},      snap_hi,    128);
    check({tag, "_load_lo"}, snap_load,  8);
    check({tag, "_overlap"}, snap_ovl,   0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int fd_seen;

    // Reset state
    rst = 1'b1;
    chain_word = 16'hFFFF;
    repeat (3) @(negedge clk);
    check("rst_joy1",  32'(joy1), 32'd0);
    check("rst_joy2",  32'(joy2), 32'd0);
    check("rst_fd",    32'(frame_done), 32'd0);
    check("rst_load",  32'(joy_load_n), 32'd1);
    check("rst_jclk",  32'(joy_clk), 32'd0);
    rst = 1'b0;
    fd_base = 0;

    @(posedge clk); #1;
    check("load_first_cycle", 32'(joy_load_n), 32'd0);
    check("jclk_in_load",     32'(joy_clk), 32'd0);

    // All released: first frame_done at cycle 264
    wait_frame();
    check("first_fd_cycle", cyc, FRAME);
    check("idle_joy1", 32'(joy1), 32'd0);
    check("idle_joy2", 32'(joy2), 32'd0);
    @(posedge clk); #1;
    check("fd_one_cycle", 32'(frame_done), 32'd0);

    // bit0 = joy1 up, bit13 = joy2 fire2
    run_frame("up_fire2",  16'hDFFE, 6'b100000, 6'b000001);
    // Unused positions 6, 7, 14, 15 low only
    run_frame("unused",    16'h3F3F, 6'b000000, 6'b000000);
    // Everything low: all buttons pressed
    run_frame("all_press", 16'h0000, 6'b111111, 6'b111111);
    // s0..s5 = 1,0,1,0,1,0 ; s8..s13 = 0,0,1,1,0,1
    run_frame("mixed",     16'hECD5, 6'b010101, 6'b110010);

    // Reset 100 cycles into a frame presenting joy1 fire1 (bit4 low)
    chain_word = 16'hFFEF;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_joy1", 32'(joy1), 32'd0);
    check("midrst_joy2", 32'(joy2), 32'd0);
    check("midrst_load", 32'(joy_load_n), 32'd1);
    check("midrst_jclk", 32'(joy_clk), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fd_base = 0;

    fd_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (i == 0) check("midrst_load_restart", 32'(joy_load_n), 32'd0);
      if (frame_done) fd_seen++;
    end
    check("midrst_no_fd",    fd_seen, 0);
    check("midrst_held_joy1", 32'(joy1), 32'd0);

    wait_frame();
`ifdef JOY_DEBOUNCE_EN
    wait_frame();
`endif
    check("after_rst_joy1", 32'(joy1), 32'b000010);
    check("after_rst_joy2", 32'(joy2), 32'd0);

    run_frame("release",   16'hFFFF, 6'b000000, 6'b000000);

`ifdef JOY_DEBOUNCE_EN
    // Left (bit2) toggling every frame never agrees with the previous frame
    for (int i = 0; i < 4; i++) begin
      chain_word = (i % 2 == 0) ? 16'hFFFB : 16'hFFFF;
      wait_frame();
      check("deb_toggle_joy1", 32'(joy1), 32'd0);
    end
    // Held for two frames: reported at the second frame_done
    chain_word = 16'hFFFB;
    wait_frame();
    check("deb_hold1_joy1", 32'(joy1), 32'd0);
    wait_frame();
    check("deb_hold2_joy1", 32'(joy1), 32'b001000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1);
  end

endmodule
